// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// classes, ALU operation codes, operand/PC select codes, opcode and funct values.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_HALT
  } iclass_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1001;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_SEXT = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

endpackage

// File: rtl/mc_decode.sv
// Purely combinational instruction decoder: opcode/funct to instruction class,
// ALU operation, B-operand select, signed/unsigned mode, overflow-trap and legal flags.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_t    cls_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] alu_src_b_o,
  output logic       usigned_o,
  output logic       trap_o,
  output logic       legal_o
);

  always_comb begin
    cls_o       = C_RALU;
    alu_op_o    = ALU_ADD;
    alu_src_b_o = SRCB_RT;
    usigned_o   = 1'b0;
    trap_o      = 1'b0;
    legal_o     = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADD:  begin usigned_o = 1'b1; trap_o = 1'b1; end
          F_ADDU: ;
          F_SUB:  begin alu_op_o = ALU_SUB; usigned_o = 1'b1; trap_o = 1'b1; end
          F_SUBU: alu_op_o = ALU_SUB;
          F_AND:  alu_op_o = ALU_AND;
          F_OR:   alu_op_o = ALU_OR;
          F_XOR:  alu_op_o = ALU_XOR;
          F_NOR:  alu_op_o = ALU_NOR;
          F_SLT:  alu_op_o = ALU_SLT;
          F_SLTU: begin alu_op_o = ALU_SLT; usigned_o = 1'b1; end
          default: legal_o = 1'b0;
        endcase
      end
      OP_ADDI: begin
        cls_o = C_IALU; alu_src_b_o = SRCB_SEXT; usigned_o = 1'b1; trap_o = 1'b1;
      end
      OP_ADDIU: begin cls_o = C_IALU; alu_src_b_o = SRCB_SEXT; end
      OP_SLTI:  begin cls_o = C_IALU; alu_src_b_o = SRCB_SEXT; alu_op_o = ALU_SLT; end
      OP_ANDI:  begin cls_o = C_IALU; alu_src_b_o = SRCB_ZEXT; alu_op_o = ALU_AND; end
      OP_ORI:   begin cls_o = C_IALU; alu_src_b_o = SRCB_ZEXT; alu_op_o = ALU_OR;  end
      OP_XORI:  begin cls_o = C_IALU; alu_src_b_o = SRCB_ZEXT; alu_op_o = ALU_XOR; end
      OP_LUI:   begin cls_o = C_IALU; alu_src_b_o = SRCB_ZEXT; alu_op_o = ALU_LUI; end
      OP_LW:    begin cls_o = C_LW;   alu_src_b_o = SRCB_SEXT; end
      OP_SW:    begin cls_o = C_SW;   alu_src_b_o = SRCB_SEXT; end
      OP_BEQ:   begin cls_o = C_BEQ;  alu_op_o = ALU_SUB; end
      OP_BNE:   begin cls_o = C_BNE;  alu_op_o = ALU_SUB; end
      OP_J:     cls_o = C_J;
      OP_HALT:  cls_o = C_HALT;
      default:  legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU controller: IF/ID/EXE/MEM/WB/HALT state machine with
// combinational control outputs and a retired-instruction counter.
module mc_control
  import mc_pkg::*;
#(
  // Value InsCount is forced to by Reset; zero for the normal machine.
  parameter logic [15:0] CNT_RST = 16'h0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        over,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [3:0]  ALUOp,
  output logic        usigned,
  output logic [2:0]  state,
  output logic        Exception,
  output logic        Illegal,
  output logic        Halted,
  output logic [15:0] InsCount
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        retire;

  iclass_t     cls;
  logic [3:0]  dec_alu_op;
  logic [1:0]  dec_src_b;
  logic        dec_usigned, dec_trap, dec_legal;

  mc_decode u_decode (
    .opcode_i    (opcode),
    .funct_i     (funct),
    .cls_o       (cls),
    .alu_op_o    (dec_alu_op),
    .alu_src_b_o (dec_src_b),
    .usigned_o   (dec_usigned),
    .trap_o      (dec_trap),
    .legal_o     (dec_legal)
  );

  always_comb begin
    state_d   = S_IF;
    retire    = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcB   = SRCB_RT;
    PCSrc     = PCSRC_SEQ;
    ALUOp     = ALU_ADD;
    usigned   = 1'b0;
    Exception = 1'b0;
    Illegal   = 1'b0;
    Halted    = 1'b0;
    // Datapath steering stays stable for the whole EXE..WB span of one instruction.
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      ALUOp    = dec_alu_op;
      ALUSrcB  = dec_src_b;
      usigned  = dec_usigned;
      RegDst   = (cls == C_RALU);
      MemtoReg = (cls == C_LW);
    end
    case (state_q)
      S_IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (!dec_legal) begin
          Illegal = 1'b1;
        end else begin
          case (cls)
            C_J: begin
              PCWrite = 1'b1;
              PCSrc   = PCSRC_JMP;
              retire  = 1'b1;
            end
            C_HALT:  state_d = S_HALT;
            default: state_d = S_EXE;
          endcase
        end
      end
      S_EXE: begin
        case (cls)
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ, C_BNE: begin
            PCWrite = (cls == C_BEQ) ? zero : ~zero;
            PCSrc   = PCSRC_BR;
            retire  = 1'b1;
          end
          default: begin
            if (dec_trap && over) Exception = 1'b1;
            else                  state_d   = S_WB;
          end
        endcase
      end
      S_MEM: begin
        if (cls == C_SW) begin
          MemWrite = 1'b1;
          retire   = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IF;
      cnt_q   <= CNT_RST;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign state    = state_q;
  assign InsCount = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-instruction cycle timelines from a table-driven model.
module tb_mc_control;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                 K_J = 6, K_HALT = 7, K_ILL = 8;
  localparam logic [15:0] W_OFS = 16'hFFF0;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, irw, rw, mw, rd, m2r;
    logic [1:0]  srcb, pcsrc;
    logic [3:0]  aluop;
    logic        us, exc, ill, hlt;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  typedef struct {
    string      nm;
    logic [5:0] op, fn;
    int         kind;
    logic [3:0] aop;
    logic [1:0] sb;
    logic       us, trap;
  } ins_t;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, over = 1'b0;

  logic PCWrite, IRWrite, RegWrite, MemWrite, RegDst, MemtoReg, usigned;
  logic Exception, Illegal, Halted;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUOp;
  logic [2:0] state;
  logic [15:0] InsCount;

  logic w_PCWrite, w_IRWrite, w_RegWrite, w_MemWrite, w_RegDst, w_MemtoReg, w_usigned;
  logic w_Exception, w_Illegal, w_Halted;
  logic [1:0] w_ALUSrcB, w_PCSrc;
  logic [3:0] w_ALUOp;
  logic [2:0] w_state;
  logic [15:0] w_InsCount;

  exp_t exp_q[$];
  ins_t tbl[$];
  logic [15:0] mcnt = '0;
  int errors = 0;
  int checks = 0;

  mc_control dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero), .over(over),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .usigned(usigned), .state(state), .Exception(Exception),
    .Illegal(Illegal), .Halted(Halted), .InsCount(InsCount)
  );

  // Second copy whose counter starts just below the wrap point.
  mc_control #(.CNT_RST(W_OFS)) dut_w (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero), .over(over),
    .PCWrite(w_PCWrite), .IRWrite(w_IRWrite), .RegWrite(w_RegWrite), .MemWrite(w_MemWrite),
    .RegDst(w_RegDst), .MemtoReg(w_MemtoReg), .ALUSrcB(w_ALUSrcB), .PCSrc(w_PCSrc),
    .ALUOp(w_ALUOp), .usigned(w_usigned), .state(w_state), .Exception(w_Exception),
    .Illegal(w_Illegal), .Halted(w_Halted), .InsCount(w_InsCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "timeout");
  end

  task automatic add_ins(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input int kind, input logic [3:0] aop, input logic [1:0] sb,
                         input logic us, input logic trap);
    ins_t t;
    t.nm = nm; t.op = op; t.fn = fn; t.kind = kind;
    t.aop = aop; t.sb = sb; t.us = us; t.trap = trap;
    tbl.push_back(t);
  endtask

  function automatic int find(input string nm);
    for (int i = 0; i < tbl.size(); i++) if (tbl[i].nm == nm) return i;
    return 0;
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t e = '0;
    e.st  = st;
    e.cnt = mcnt;
    return e;
  endfunction

  function automatic obs_t held(input obs_t e0, input ins_t t);
    obs_t e = e0;
    e.aluop = t.aop;
    e.srcb  = t.sb;
    e.us    = t.us;
    e.rd    = (t.kind == K_R);
    e.m2r   = (t.kind == K_LW);
    return e;
  endfunction

  task automatic post(input obs_t e, input string tag);
    exp_t x;
    x.o = e; x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic reset_pulse();
    obs_t e;
    Reset = 1'b1;
    mcnt = '0;
    e = mk(3'd0); e.pcw = 1'b1; e.irw = 1'b1;
    post(e, "reset");
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  // Timeline of one instruction; abort>=0 asserts Reset after that many cycles.
  task automatic issue(input int idx, input logic z, input logic ov, input int abort);
    ins_t t = tbl[idx];
    obs_t seq[$];
    obs_t e;
    bit ret = 1'b0;
    int ncyc;
    opcode = t.op; funct = t.fn; zero = z; over = ov;
    e = mk(3'd0); e.pcw = 1'b1; e.irw = 1'b1; seq.push_back(e);
    e = mk(3'd1);
    if (t.kind == K_J) begin
      e.pcw = 1'b1; e.pcsrc = 2'b10; seq.push_back(e); ret = 1'b1;
    end else if (t.kind == K_ILL) begin
      e.ill = 1'b1; seq.push_back(e);
    end else if (t.kind == K_HALT) begin
      seq.push_back(e);
    end else begin
      seq.push_back(e);
      e = held(mk(3'd2), t);
      if (t.kind == K_BEQ || t.kind == K_BNE) begin
        e.pcw = (t.kind == K_BEQ) ? z : !z; e.pcsrc = 2'b01; seq.push_back(e); ret = 1'b1;
      end else if (t.kind == K_LW || t.kind == K_SW) begin
        seq.push_back(e);
        e = held(mk(3'd3), t);
        if (t.kind == K_SW) begin
          e.mw = 1'b1; seq.push_back(e);
        end else begin
          seq.push_back(e);
          e = held(mk(3'd4), t); e.rw = 1'b1; seq.push_back(e);
        end
        ret = 1'b1;
      end else if (t.trap && ov) begin
        e.exc = 1'b1; seq.push_back(e);
      end else begin
        seq.push_back(e);
        e = held(mk(3'd4), t); e.rw = 1'b1; seq.push_back(e); ret = 1'b1;
      end
    end
    ncyc = (abort >= 0 && abort < seq.size()) ? abort : seq.size();
    for (int i = 0; i < ncyc; i++) post(seq[i], t.nm);
    if (ncyc > 0) begin
      repeat (ncyc) @(posedge CLK);
      #1;
    end
    if (ret && ncyc == seq.size()) mcnt = mcnt + 16'd1;
    if (abort >= 0) reset_pulse();
  endtask

  task automatic run_halt(input int k);
    obs_t e;
    issue(find("halt"), 1'b0, 1'b0, -1);
    for (int i = 0; i < k; i++) begin
      e = mk(3'd5); e.hlt = 1'b1; post(e, "halted");
    end
    repeat (k) @(posedge CLK);
    #1;
    reset_pulse();
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  initial begin
    exp_t x;
    obs_t a, w, we;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a = {state, PCWrite, IRWrite, RegWrite, MemWrite, RegDst, MemtoReg, ALUSrcB, PCSrc,
             ALUOp, usigned, Exception, Illegal, Halted, InsCount};
        w = {w_state, w_PCWrite, w_IRWrite, w_RegWrite, w_MemWrite, w_RegDst, w_MemtoReg,
             w_ALUSrcB, w_PCSrc, w_ALUOp, w_usigned, w_Exception, w_Illegal, w_Halted,
             w_InsCount};
        we = x.o;
        we.cnt = x.o.cnt + W_OFS;
        checks++;
        if (a !== x.o) begin
          errors++;
          $display("FAIL %s @%0t: got %h (st=%0d cnt=%h) want %h (st=%0d cnt=%h)",
                   x.tag, $time, a, a.st, a.cnt, x.o, x.o.st, x.o.cnt);
        end
        checks++;
        if (w !== we) begin
          errors++;
          $display("FAIL %s-wrapcopy @%0t: got %h (cnt=%h) want %h (cnt=%h)",
                   x.tag, $time, w, w.cnt, we, we.cnt);
        end
      end
    end
  end

  initial begin
    int idx, ab;
    logic z, ov;
    add_ins("add",   6'h00, 6'h20, K_R, 4'b0000, 2'b00, 1, 1);
    add_ins("addu",  6'h00, 6'h21, K_R, 4'b0000, 2'b00, 0, 0);
    add_ins("sub",   6'h00, 6'h22, K_R, 4'b0001, 2'b00, 1, 1);
    add_ins("subu",  6'h00, 6'h23, K_R, 4'b0001, 2'b00, 0, 0);
    add_ins("and",   6'h00, 6'h24, K_R, 4'b0010, 2'b00, 0, 0);
    add_ins("or",    6'h00, 6'h25, K_R, 4'b0011, 2'b00, 0, 0);
    add_ins("xor",   6'h00, 6'h26, K_R, 4'b0100, 2'b00, 0, 0);
    add_ins("nor",   6'h00, 6'h27, K_R, 4'b0101, 2'b00, 0, 0);
    add_ins("slt",   6'h00, 6'h2A, K_R, 4'b1001, 2'b00, 0, 0);
    add_ins("sltu",  6'h00, 6'h2B, K_R, 4'b1001, 2'b00, 1, 0);
    add_ins("addi",  6'h08, 6'h15, K_I, 4'b0000, 2'b01, 1, 1);
    add_ins("addiu", 6'h09, 6'h00, K_I, 4'b0000, 2'b01, 0, 0);
    add_ins("slti",  6'h0A, 6'h2A, K_I, 4'b1001, 2'b01, 0, 0);
    add_ins("andi",  6'h0C, 6'h3F, K_I, 4'b0010, 2'b10, 0, 0);
    add_ins("ori",   6'h0D, 6'h01, K_I, 4'b0011, 2'b10, 0, 0);
    add_ins("xori",  6'h0E, 6'h20, K_I, 4'b0100, 2'b10, 0, 0);
    add_ins("lui",   6'h0F, 6'h07, K_I, 4'b0110, 2'b10, 0, 0);
    add_ins("lw",    6'h23, 6'h20, K_LW, 4'b0000, 2'b01, 0, 0);
    add_ins("sw",    6'h2B, 6'h22, K_SW, 4'b0000, 2'b01, 0, 0);
    add_ins("beq",   6'h04, 6'h00, K_BEQ, 4'b0001, 2'b00, 0, 0);
    add_ins("bne",   6'h05, 6'h2B, K_BNE, 4'b0001, 2'b00, 0, 0);
    add_ins("j",     6'h02, 6'h20, K_J, 4'b0000, 2'b00, 0, 0);
    add_ins("halt",  6'h3F, 6'h00, K_HALT, 4'b0000, 2'b00, 0, 0);
    add_ins("ill_op11", 6'h11, 6'h20, K_ILL, 4'b0000, 2'b00, 0, 0);
    add_ins("ill_fn3F", 6'h00, 6'h3F, K_ILL, 4'b0000, 2'b00, 0, 0);

    @(posedge CLK); #1;
    reset_pulse();

    issue(find("add"),  1'b0, 1'b0, -1);
    issue(find("lw"),   1'b0, 1'b0, -1);
    issue(find("sw"),   1'b1, 1'b0, -1);
    issue(find("beq"),  1'b1, 1'b0, -1);
    issue(find("beq"),  1'b0, 1'b0, -1);
    issue(find("bne"),  1'b1, 1'b0, -1);
    issue(find("bne"),  1'b0, 1'b0, -1);
    issue(find("add"),  1'b0, 1'b1, -1);
    issue(find("sub"),  1'b0, 1'b1, -1);
    issue(find("addi"), 1'b0, 1'b1, -1);
    issue(find("addu"), 1'b0, 1'b1, -1);
    issue(find("sltu"), 1'b0, 1'b0, -1);
    issue(find("ill_op11"), 1'b0, 1'b0, -1);
    issue(find("j"),    1'b0, 1'b0, -1);
    issue(find("lw"),   1'b0, 1'b0, 3);
    issue(find("ori"),  1'b0, 1'b0, -1);
    run_halt(100);
    for (int i = 0; i < 20; i++) issue(find("j"), 1'b0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      idx = int'($urandom_range(0, tbl.size() - 1));
      z   = 1'($urandom_range(0, 1));
      ov  = 1'($urandom_range(0, 1));
      if (tbl[idx].kind == K_HALT) begin
        run_halt(int'($urandom_range(2, 6)));
      end else begin
        ab = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 4)) : -1;
        issue(idx, z, ov, ab);
      end
    end

    @(negedge CLK); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK in 1 (all state on rising edge); Reset in 1 (asynchronous, active-high).
REQ-002 Ports SHALL be: opcode in 6 IR[31:26]; funct in 6 IR[5:0]; zero in 1 from ALU; over in 1 from ALU.
REQ-003 Ports SHALL be: PCWrite out 1; IRWrite out 1; RegWrite out 1; MemWrite out 1; RegDst out 1 (0 rt, 1 rd); MemtoReg out 1 (0 ALU result, 1 memory data).
REQ-004 Ports SHALL be: ALUSrcB out 2 (00 rt, 01 sign-ext imm, 10 zero-ext imm); PCSrc out 2 (00 PC+4, 01 branch target, 10 jump target); ALUOp out 4; usigned out 1.
REQ-005 Ports SHALL be: state out 3 (current state); Exception out 1 (overflow pulse); Illegal out 1 (undefined-instruction pulse); Halted out 1; InsCount out 16 (retired instructions).

Function
REQ-006 States SHALL be IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101; codes 110/111 SHALL go to IF on the next edge.
REQ-007 IF: IRWrite=1, PCWrite=1, PCSrc=00; next ID unconditionally.
REQ-008 ID: j (000010) -> PCWrite=1, PCSrc=10, next IF; halt (111111) -> next HALT; undefined opcode/funct -> Illegal=1 for one cycle, next IF; all others -> EXE.
REQ-009 EXE: R-type/I-type ALU -> WB; lw (100011)/sw (101011) -> MEM with ALUOp=ADD, ALUSrcB=01, usigned=0.
REQ-010 EXE beq (000100)/bne (000101): ALUOp=SUB, ALUSrcB=00, usigned=0; PCWrite=zero (beq) or ~zero (bne), PCSrc=01; next IF.
REQ-011 EXE: if over=1 for add/sub/addi, Exception=1 for that cycle, next IF, WB skipped (no RegWrite).
REQ-012 MEM: lw -> next WB; sw -> MemWrite=1, next IF.
REQ-013 WB: RegWrite=1; RegDst=1 for R-type else 0; MemtoReg=1 for lw else 0; next IF.
REQ-014 HALT: all write enables 0, Halted=1, remains until Reset.
REQ-015 ALUOp codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, LUI 0110, SLT 1001.
REQ-016 Decode: add/addu/addi/addiu->ADD; sub/subu->SUB; and/andi->AND; or/ori->OR; xor/xori->XOR; nor->NOR; lui->LUI; slt/sltu/slti->SLT.
REQ-017 usigned=1 SHALL be driven for add, sub, addi (overflow trap) and sltu (unsigned compare); 0 otherwise.
REQ-018 ALUSrcB: 01 for addi/addiu/slti/lw/sw; 10 for andi/ori/xori/lui; 00 otherwise.
REQ-019 ALUOp/ALUSrcB/usigned/RegDst/MemtoReg SHALL be held from EXE through WB for the same instruction; outside those states ALUOp=ADD, others 0.
REQ-020 All outputs except state and InsCount SHALL be combinational from registered state, opcode, funct, zero, over; no write enable SHALL assert outside the state listed for it.
REQ-021 InsCount SHALL increment by 1 on each edge leaving WB, MEM(sw), EXE(branch) or ID(j); not on Exception or Illegal; wraps FFFF->0000.

Reset
REQ-022 Reset SHALL asynchronously force state=IF, InsCount=0; with Reset high outputs equal IF-state values.
REQ-023 Reset asserted mid-instruction SHALL abort it with no further RegWrite/MemWrite; first edge after release executes IF.

Structure
REQ-024 Package mc_pkg SHALL hold state encodings, ALUOp codes, opcode and funct constants.
REQ-025 One combinational sub-module mc_decode SHALL map opcode/funct to instruction class, ALUOp, ALUSrcB, usigned, legal flag; mc_control holds the FSM and counter.

Verification
REQ-026 add (op 0, funct 100000), over=0 -> IF,ID,EXE,WB; RegWrite=1 only in WB with RegDst=1; InsCount 0->1.
REQ-027 lw -> 5 cycles IF,ID,EXE,MEM,WB, MemtoReg=1 in WB; sw -> 4 cycles, MemWrite=1 only in MEM.
REQ-028 beq zero=1 -> PCWrite=1, PCSrc=01 in EXE; zero=0 -> PCWrite=0; bne inverse; 3 cycles each.
REQ-029 add with over=1 in EXE -> Exception pulse 1 cycle, no RegWrite, next IF, InsCount unchanged; undefined opcode 010001 -> Illegal in ID, next IF.
REQ-030 halt -> HALT, Halted=1 held 100 cycles; Reset pulse in HALT or MEM of lw -> state=IF immediately, InsCount=0, no WB.
REQ-031 InsCount preset near FFFF by 65535 retired j instructions -> next retire reads 0000.
